// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types for the data-memory arbiter
// Purpose: request/response record types and port count used by dmem_arbiter
//          and dmem_rsp_slot.
package dmem_pkg;

  localparam int NPORTS = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

endpackage

// File: rtl/dmem_rsp_slot.sv
// rtl/dmem_rsp_slot.sv - one-entry registered response holder for one port
// Purpose: holds a port's response (valid/rdata/err) until the requester
//          takes it, and tells the arbiter when the port may be granted again.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   load             port was granted this cycle; capture load_rdata/load_err
//   load_rdata/err   response computed for the granted access
//   rsp_ready        requester consumes the held response
//   rsp_valid/rdata/err  registered response towards the requester
//   can_accept       slot is free now or frees at this edge
module dmem_rsp_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_rdata,
  input  logic        load_err,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        can_accept
);

  // A held response that retires this cycle frees the slot in time for a
  // back-to-back grant, giving one access per cycle per port.
  assign can_accept = ~rsp_valid | rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= load_rdata;
      rsp_err   <= load_err;
    end else if (rsp_valid && rsp_ready) begin
      // rdata/err deliberately keep their last values after retire
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter for the single-port data memory
// Purpose: shares one data memory between port 0 (CPU LSU) and port 1
//          (debug/DMA loader); one access per cycle, combinational grant,
//          registered response per port.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   pN_req/we/addr/wdata            access request of port N
//   pN_gnt                          request accepted this cycle
//   pN_rsp_valid/ready/rdata/err    response handshake of port N
//   mem_we/mem_a/mem_wd/mem_rd      memory interface (mem_rd combinational)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rsp_valid,
  input  logic        p0_rsp_ready,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rsp_valid,
  input  logic        p1_rsp_ready,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  mem_req_t [NPORTS-1:0] req;
  logic     [NPORTS-1:0] req_v;
  logic     [NPORTS-1:0] can_acc;
  logic     [NPORTS-1:0] elig;
  logic     [NPORTS-1:0] win;
  logic     [NPORTS-1:0] rsp_ready;
  logic     [NPORTS-1:0] rsp_valid;
  logic     [NPORTS-1:0] rsp_err;
  logic     [31:0]       rsp_rdata [NPORTS];

  mem_req_t sel;
  mem_rsp_t new_rsp;
  logic     grant_any;
  logic     in_range;
  // Port that received the most recent grant; starts at 1 so port 0 wins
  // the first tie after reset.
  logic     last_gnt;

  assign req[0]       = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
  assign req[1]       = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};
  assign req_v        = {p1_req, p0_req};
  assign rsp_ready    = {p1_rsp_ready, p0_rsp_ready};

  always_comb begin
    elig = reset ? '0 : (req_v & can_acc);
    win  = elig;
    if (elig == 2'b11) begin
      win = last_gnt ? 2'b01 : 2'b10;
    end
  end

  assign grant_any = |win;
  assign sel       = win[1] ? req[1] : req[0];
  // Full 32-bit compare so huge addresses never alias into the array.
  assign in_range  = (sel.addr < SIZE);

  assign p0_gnt = win[0];
  assign p1_gnt = win[1];

  assign mem_we = grant_any & sel.we & in_range;
  assign mem_a  = grant_any ? sel.addr  : 32'h0;
  assign mem_wd = grant_any ? sel.wdata : 32'h0;

  // Response for whichever port won; only the winner's slot loads it.
  assign new_rsp.rdata = (~sel.we & in_range) ? mem_rd : 32'h0;
  assign new_rsp.err   = ~in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (grant_any) begin
      last_gnt <= win[1];
    end
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_slot
    dmem_rsp_slot u_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (win[i]),
      .load_rdata (new_rsp.rdata),
      .load_err   (new_rsp.err),
      .rsp_ready  (rsp_ready[i]),
      .rsp_valid  (rsp_valid[i]),
      .rsp_rdata  (rsp_rdata[i]),
      .rsp_err    (rsp_err[i]),
      .can_accept (can_acc[i])
    );
  end

  assign p0_rsp_valid = rsp_valid[0];
  assign p0_rsp_rdata = rsp_rdata[0];
  assign p0_rsp_err   = rsp_err[0];
  assign p1_rsp_valid = rsp_valid[1];
  assign p1_rsp_rdata = rsp_rdata[1];
  assign p1_rsp_err   = rsp_err[1];

endmodule
